// File: rtl/vga_rx_monitor.sv
// VGA stream sink: measures hs/vs timing against expected totals, checksums each frame, tracks lock.
// Latency: statistics and pulses are registered, visible one pclk after the triggering sample; locked one more.
// Backpressure: none; passive sink that samples every pclk cycle and never stalls the source.
module vga_rx_monitor #(
  parameter int H_TOTAL = 1056,
  parameter int V_TOTAL = 628,
  parameter int H_SYNC  = 128,
  parameter int V_SYNC  = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [11:0] line_len,
  output logic [11:0] hs_width,
  output logic [10:0] frame_lines,
  output logic [10:0] vs_width,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_frame,
  output logic [7:0]  err_cnt,
  output logic        locked
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state;
  logic        hs_d;
  logic        vs_d;
  logic        hs_seen;   // an hs rise has been seen since reset
  logic        vs_seen;   // a vs rise has been seen since reset (frame opened)
  logic        bad;       // a line error occurred in the current frame
  logic [11:0] pix_cnt;
  logic [11:0] hsw_cnt;
  logic [10:0] line_cnt;
  logic [10:0] vsw_cnt;
  logic [15:0] acc;

  logic        hs_rise;
  logic        hs_fall;
  logic        vs_rise;
  logic        vs_fall;
  logic [12:0] pix_next;
  logic [11:0] vsw_sum;
  logic [10:0] vsw_sat;
  logic [15:0] rgb16;
  logic        line_err;
  logic        frame_err;

  assign hs_rise  = hs & ~hs_d;
  assign hs_fall  = ~hs & hs_d;
  assign vs_rise  = vs & ~vs_d;
  assign vs_fall  = ~vs & vs_d;
  assign rgb16    = {4'd0, r, g, b};
  // one extra bit so a saturated pix_cnt still compares as "too long"
  assign pix_next = {1'b0, pix_cnt} + 13'd1;
  // an hs rise coincident with the vs fall still belongs to the sync pulse
  assign vsw_sum  = {1'b0, vsw_cnt} + {11'd0, hs_rise & vs_d};
  assign vsw_sat  = vsw_sum[11] ? 11'h7FF : vsw_sum[10:0];

  assign line_err  = (hs_rise & hs_seen & (pix_next != 13'(H_TOTAL)))
                   | (hs_fall & (hsw_cnt != 12'(H_SYNC)));
  assign frame_err = vs_rise & vs_seen
                   & ((line_cnt != 11'(V_TOTAL)) | (vs_width != 11'(V_SYNC)));

  // Delayed sync copies for edge detection
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
    end
  end

  // Line timing: period between hs rises and hs pulse width, both saturating
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      pix_cnt  <= 12'd0;
      hsw_cnt  <= 12'd0;
      line_len <= 12'd0;
      hs_width <= 12'd0;
      hs_seen  <= 1'b0;
    end else begin
      if (hs_rise) begin
        pix_cnt <= 12'd0;
        hs_seen <= 1'b1;
        if (hs_seen) begin
          line_len <= pix_next[12] ? 12'hFFF : pix_next[11:0];
        end
      end else if (pix_cnt != 12'hFFF) begin
        pix_cnt <= pix_next[11:0];
      end
      if (hs_fall) begin
        hs_width <= hsw_cnt;
        hsw_cnt  <= 12'd0;
      end else if (hs && (hsw_cnt != 12'hFFF)) begin
        hsw_cnt <= hsw_cnt + 12'd1;
      end
    end
  end

  // Frame timing and checksum; the first vs rise only opens a frame
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      line_cnt    <= 11'd0;
      vsw_cnt     <= 11'd0;
      acc         <= 16'd0;
      frame_lines <= 11'd0;
      vs_width    <= 11'd0;
      frame_sum   <= 16'd0;
      frame_done  <= 1'b0;
      vs_seen     <= 1'b0;
    end else begin
      frame_done <= vs_rise & vs_seen;
      if (vs_rise) begin
        acc      <= rgb16;
        line_cnt <= {10'd0, hs_rise};
        vs_seen  <= 1'b1;
        if (vs_seen) begin
          frame_lines <= line_cnt;
          frame_sum   <= acc;
        end
      end else begin
        acc <= acc + rgb16;
        if (hs_rise && (line_cnt != 11'h7FF)) begin
          line_cnt <= line_cnt + 11'd1;
        end
      end
      if (vs_fall) begin
        vs_width <= vsw_sat;
        vsw_cnt  <= 11'd0;
      end else begin
        vsw_cnt <= vsw_sat;
      end
    end
  end

  // Error pulses, saturating error count and the frame-local bad flag
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      err_cnt   <= 8'd0;
      bad       <= 1'b0;
    end else begin
      err_line  <= line_err;
      err_frame <= frame_err;
      if ((line_err | frame_err) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (vs_rise) begin
        bad <= 1'b0;
      end else if (line_err) begin
        bad <= 1'b1;
      end
    end
  end

  // Lock FSM; locked follows the state one cycle later
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      locked <= (state == LOCKED);
      case (state)
        SEARCH: begin
          if (vs_rise) state <= CHECK;
        end
        CHECK: begin
          if (vs_rise && !frame_err && !bad && !line_err) state <= LOCKED;
        end
        LOCKED: begin
          if (line_err || frame_err) state <= CHECK;
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
